// File: rtl/cycle_averager_pkg.sv
// Shared state encoding and default widths for the cycle averager.
package cycle_averager_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_PASS_WIDTH = 19;
    localparam int DEF_ACC_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ALIGN = 2'd1,
        ST_ACCUMULATE = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/cycle_averager_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with a
// registered (1-cycle) read. Read-during-write to one address returns old data.
module cycle_averager_ram
    import cycle_averager_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ACC_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ACC_WIDTH-1:0]  rd_data
);

    logic [ACC_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // NOTE: the array has no reset on purpose; a reset term would stop it mapping to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cycle_averager.sv
// Multi-pass per-bin averager: accumulates signed samples into a RAM bin by
// bin over n_avg aligned passes, then exposes the sums through rd_addr/rd_data.
module cycle_averager
    import cycle_averager_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PASS_WIDTH = DEF_PASS_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] n_avg,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic [ADDR_WIDTH-1:0] bin,
    input  logic                  end_cycle,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ACC_WIDTH-1:0]  rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [PASS_WIDTH-1:0] pass_count
);

    state_t                state;
    logic [PASS_WIDTH-1:0] n_lat;
    logic [PASS_WIDTH-1:0] pass_next;
    logic                  first_pass;
    logic                  finishing;
    logic                  accept;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_bin;
    logic [ACC_WIDTH-1:0]  s1_din;
    logic                  s1_first;

    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_bin;
    logic [ACC_WIDTH-1:0]  fwd_data;

    logic [ACC_WIDTH-1:0]  ram_q;
    logic [ACC_WIDTH-1:0]  base;
    logic [ACC_WIDTH-1:0]  sum;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [ACC_WIDTH-1:0]  din_ext;

    assign din_ext     = {{(ACC_WIDTH-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
    assign pass_next   = pass_count + PASS_WIDTH'(1);
    // Once the final end_cycle is taken, later samples belong to no pass.
    assign accept      = (state == ST_ACCUMULATE) && !finishing && din_valid && !start;
    assign ram_rd_addr = busy ? bin : rd_addr;
    assign rd_data     = ram_q;

    // NOTE: default first so every path assigns base and no latch is inferred.
    always_comb begin
        base = ram_q;
        if (s1_first) begin
            base = '0;
        end else if (fwd_valid && (fwd_bin == s1_bin)) begin
            // The RAM read for this sample overlapped the previous write to the same bin.
            base = fwd_data;
        end
    end

    assign sum = base + s1_din;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_count <= '0;
            n_lat      <= PASS_WIDTH'(1);
            first_pass <= 1'b1;
            finishing  <= 1'b0;
        end else if (start) begin
            state      <= ST_WAIT_ALIGN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass_count <= '0;
            n_lat      <= (n_avg == '0) ? PASS_WIDTH'(1) : n_avg;
            first_pass <= 1'b1;
            finishing  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_ALIGN: begin
                    if (din_valid && end_cycle) begin
                        state      <= ST_ACCUMULATE;
                        first_pass <= 1'b1;
                    end
                end
                ST_ACCUMULATE: begin
                    if (finishing) begin
                        // The final write committed on this edge.
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        finishing <= 1'b0;
                    end else if (accept && end_cycle) begin
                        first_pass <= 1'b0;
                        if (pass_count < n_lat) begin
                            pass_count <= pass_next;
                        end
                        if (pass_next >= n_lat) begin
                            finishing <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_bin    <= '0;
            s1_din    <= '0;
            s1_first  <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_bin   <= '0;
            fwd_data  <= '0;
        end else begin
            s1_valid  <= accept;
            s1_bin    <= bin;
            s1_din    <= din_ext;
            s1_first  <= first_pass;
            fwd_valid <= s1_valid;
            fwd_bin   <= s1_bin;
            fwd_data  <= sum;
        end
    end

    cycle_averager_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .we      (s1_valid),
        .wr_addr (s1_bin),
        .wr_data (sum),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_cycle_averager.sv
// Scoreboarded bench for cycle_averager: directed runs, readouts checked by a monitor.
module tb_cycle_averager;

    localparam int DW   = 14;
    localparam int AW   = 13;
    localparam int PW   = 19;
    localparam int ACCW = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic [PW-1:0]   n_avg = '0;
    logic [DW-1:0]   din = '0;
    logic            din_valid = 1'b0;
    logic [AW-1:0]   bin = '0;
    logic            end_cycle = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [ACCW-1:0] rd_data;
    logic            busy;
    logic            done;
    logic [PW-1:0]   pass_count;

    typedef struct {
        string           name;
        logic [ACCW-1:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic rd_strobe = 1'b0;
    logic rd_strobe_d = 1'b0;

    always #5 clk = ~clk;

    cycle_averager #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PASS_WIDTH (PW),
        .ACC_WIDTH  (ACCW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .n_avg      (n_avg),
        .din        (din),
        .din_valid  (din_valid),
        .bin        (bin),
        .end_cycle  (end_cycle),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count)
    );

    task automatic check(input string name, input logic [ACCW-1:0] actual,
                         input logic [ACCW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(actual), actual, $signed(expected), expected);
        end
    endtask

    // Monitor: a read address presented on one edge yields rd_data after it.
    always @(posedge clk) rd_strobe_d <= rd_strobe;

    always @(negedge clk) begin
        if (rd_strobe_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got read data 0x%08h with no expected entry", rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, rd_data, e.value);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int b, input int d, input bit e);
        din_valid = 1'b1;
        bin       = AW'(b);
        din       = DW'(d);
        end_cycle = e;
        tick();
        din_valid = 1'b0;
        end_cycle = 1'b0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        n_avg = PW'(n);
        tick();
        start = 1'b0;
    endtask

    // din for bin k is d0 + k*dk; optional random idle gaps between samples.
    task automatic run_passes(input int np, input int nb, input int d0, input int dk,
                              input bit gaps);
        for (int p = 0; p < np; p++) begin
            for (int k = 0; k < nb; k++) begin
                send(k, d0 + k * dk, k == nb - 1);
                if (gaps) repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 && !done; i++) tick();
        check(name, ACCW'(done), 1);
    endtask

    task automatic read_bin(input string name, input int k, input int value);
        rd_addr   = AW'(k);
        rd_strobe = 1'b1;
        exp_q.push_back('{name: $sformatf("%s_bin%0d", name, k), value: ACCW'(value)});
        tick();
    endtask

    task automatic read_end();
        rd_strobe = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_busy", ACCW'(busy), 0);
        check("rst_done", ACCW'(done), 0);
        check("rst_pass_count", ACCW'(pass_count), 0);
        check("rst_rd_data", rd_data, 0);
        tick();
        resetn = 1'b1;
        tick();

        // 8 bins, din=bin+1, four passes
        do_start(4);
        check("s1_busy", ACCW'(busy), 1);
        send(7, 0, 1);
        run_passes(4, 8, 1, 1, 1'b0);
        wait_done("s1_done");
        check("s1_pass_count", ACCW'(pass_count), 4);
        check("s1_busy_after", ACCW'(busy), 0);
        for (int k = 0; k < 8; k++) read_bin("s1", k, 4 * (k + 1));
        read_end();

        // Single-bin passes exercise back-to-back forwarding
        do_start(5);
        send(0, 0, 1);
        run_passes(5, 1, 3, 0, 1'b0);
        wait_done("s2_done");
        check("s2_pass_count", ACCW'(pass_count), 5);
        read_bin("s2", 0, 15);
        read_end();

        // Most negative sample, sign extension
        do_start(3);
        send(3, 0, 1);
        run_passes(3, 4, -8192, 0, 1'b0);
        wait_done("s3_done");
        for (int k = 0; k < 4; k++) read_bin("s3", k, -24576);
        read_end();

        // n_avg=0 behaves as a single pass; done holds until next start
        do_start(0);
        send(3, 0, 1);
        run_passes(1, 4, -5, 2, 1'b0);
        wait_done("s4_done");
        check("s4_pass_count", ACCW'(pass_count), 1);
        for (int k = 0; k < 4; k++) read_bin("s4", k, -5 + 2 * k);
        read_end();
        repeat (5) tick();
        check("s4_done_hold", ACCW'(done), 1);

        // Start mid-pass, then a second start mid-run
        for (int k = 0; k < 5; k++) send(k, 100 + k, 1'b0);
        start = 1'b1;
        n_avg = PW'(2);
        send(5, 105, 1'b0);
        start = 1'b0;
        send(6, 106, 1'b0);
        send(7, 107, 1'b1);
        run_passes(1, 8, 100, 1, 1'b0);
        for (int k = 0; k < 3; k++) send(k, 100 + k, 1'b0);
        start = 1'b1;
        send(3, 103, 1'b0);
        start = 1'b0;
        for (int k = 4; k < 8; k++) send(k, 100 + k, k == 7);
        run_passes(2, 8, 100, 1, 1'b0);
        wait_done("s5_done");
        check("s5_pass_count", ACCW'(pass_count), 2);
        for (int k = 0; k < 8; k++) read_bin("s5", k, 2 * (100 + k));
        read_end();

        // Gapped din_valid matches the continuous result
        do_start(2);
        send(7, 0, 1);
        run_passes(2, 8, 1, 1, 1'b1);
        wait_done("s6_done");
        for (int k = 0; k < 8; k++) read_bin("s6", k, 2 * (k + 1));
        read_end();

        // Reset during accumulation; RAM keeps contents, samples ignored afterwards
        do_start(4);
        send(7, 0, 1);
        for (int k = 0; k < 4; k++) send(k, 50 + k, 1'b0);
        tick();
        #3;
        resetn = 1'b0;
        #1;
        check("s7_rst_busy", ACCW'(busy), 0);
        check("s7_rst_done", ACCW'(done), 0);
        check("s7_rst_pass_count", ACCW'(pass_count), 0);
        check("s7_rst_rd_data", rd_data, 0);
        tick();
        tick();
        resetn = 1'b1;
        run_passes(2, 8, 999, 0, 1'b0);
        check("s7_idle_busy", ACCW'(busy), 0);
        check("s7_idle_done", ACCW'(done), 0);
        for (int k = 0; k < 8; k++) read_bin("s7", k, (k < 4) ? (50 + k) : 2 * (k + 1));
        read_end();

        check("sb_drain", ACCW'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
